// File: rtl/uart_tx_if.sv
// Host-side bundle of the UART transmitter: push port, CTS input,
// serial line and FIFO status. The transmitter takes the slave side.
interface uart_tx_if #(
  parameter int DataLength = 8,
  parameter int FifoDepth  = 8
);
  logic [DataLength-1:0]              tx_data;
  logic                               tx_req;
  logic                               cts;
  logic                               tx;
  logic                               tx_busy;
  logic                               tx_full;
  logic                               tx_empty;
  logic                               tx_ovf;
  logic [$clog2(FifoDepth+1)-1:0]     fifo_count;

  modport master (
    output tx_data, tx_req, cts,
    input  tx, tx_busy, tx_full, tx_empty, tx_ovf, fifo_count
  );

  modport slave (
    input  tx_data, tx_req, cts,
    output tx, tx_busy, tx_full, tx_empty, tx_ovf, fifo_count
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter: push FIFO feeding a start/data/stop serialiser.
// Frames are LSB first with one stop bit; CTS is only consulted
// between frames, so a frame in flight always completes.
module uart_tx_core #(
  parameter int DataLength      = 8,
  parameter int FifoDepth       = 8,
  parameter int BaudRate        = 115200,
  parameter int SystemClockFreq = 50_000_000
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  uart_tx_if.slave bus
);
  localparam int BitCycles = SystemClockFreq / BaudRate;
  localparam int CntW      = $clog2(FifoDepth + 1);
  localparam int PtrW      = $clog2(FifoDepth);
  localparam int BaudW     = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam int BitW      = $clog2(DataLength + 1);

  localparam logic [BaudW-1:0] BaudLast = BaudW'(BitCycles - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DataLength - 1);
  localparam logic [CntW-1:0]  Depth    = CntW'(FifoDepth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [DataLength-1:0] mem [FifoDepth];
  logic [PtrW-1:0]       wr_ptr;
  logic [PtrW-1:0]       rd_ptr;
  logic [CntW-1:0]       count;
  logic [CntW-1:0]       count_next;
  logic                  full_q;
  logic                  empty_q;
  logic                  ovf_q;
  logic [DataLength-1:0] shift_reg;
  logic [BaudW-1:0]      baud_cnt;
  logic [BitW-1:0]       bit_cnt;
  logic                  tx_q;
  logic                  busy_q;
  logic                  push_ok;
  logic                  pop;
  logic                  baud_end;

  // A push into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign push_ok  = bus.tx_req && (count != Depth);
  assign pop      = (state == IDLE) && (count != '0) && bus.cts;
  assign baud_end = (baud_cnt == BaudLast);

  // Occupancy after this edge; full/empty are registered from it.
  always_comb begin
    count_next = count;
    if (push_ok && !pop) begin
      count_next = count + CntW'(1);
    end else if (pop && !push_ok) begin
      count_next = count - CntW'(1);
    end
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= bus.tx_data;
    end
  end

  // FIFO pointers, occupancy and status flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)     rd_ptr <= rd_ptr + PtrW'(1);
      count   <= count_next;
      full_q  <= (count_next == Depth);
      empty_q <= (count_next == '0);
      ovf_q   <= bus.tx_req && (count == Depth);
    end
  end

  // Frame sequencer; o_tx is a flop so the line never glitches.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            shift_reg <= mem[rd_ptr];
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            tx_q     <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == BitLast) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + BitW'(1);
              shift_reg <= shift_reg >> 1;
              tx_q      <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BaudW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_full    = full_q;
  assign bus.tx_empty   = empty_q;
  assign bus.tx_ovf     = ovf_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core at a reduced baud divisor (1 MHz / 60 kBd -> 16
// clocks per bit), so a frame is 160 clocks and start edges 161 apart.
module tb_uart_tx_core;
  localparam int DL     = 8;
  localparam int DEPTH  = 8;
  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 60_000;
  localparam int BC     = CLK_HZ / BAUD;
  localparam int FRAME  = (DL + 2) * BC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if #(.DataLength(DL), .FifoDepth(DEPTH)) bus();

  uart_tx_core #(
    .DataLength(DL), .FifoDepth(DEPTH),
    .BaudRate(BAUD), .SystemClockFreq(CLK_HZ)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  bit done     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word queue plus the position inside the frame on the line.
  logic [DL-1:0] mq[$];
  bit            m_active = 1'b0;
  int            m_e      = 0;
  logic [DL-1:0] m_word   = '0;
  bit            m_ovf    = 1'b0;

  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_e / BC;
    if (idx == 0) return 1'b0;
    if (idx <= DL) return m_word[idx-1];
    return 1'b1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_active = 1'b0;
        m_e      = 0;
        m_ovf    = 1'b0;
      end else begin
        int  sz;
        bit  do_pop;
        bit  do_push;
        sz      = mq.size();
        do_pop  = !m_active && (sz > 0) && bus.cts;
        do_push = bus.tx_req && (sz < DEPTH);
        m_ovf   = bus.tx_req && (sz == DEPTH);
        if (m_active) begin
          m_e++;
          if (m_e == FRAME) m_active = 1'b0;
        end
        if (do_pop) begin
          m_word   = mq.pop_front();
          m_active = 1'b1;
          m_e      = 0;
        end
        if (do_push) mq.push_back(bus.tx_data);
      end
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int rise_cyc[$];
  int len_log[$];
  bit prev_busy = 1'b0;
  int busy_len  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!done) begin
        check("tx",    32'(bus.tx),         32'(exp_tx()));
        check("busy",  32'(bus.tx_busy),    32'(m_active));
        check("count", 32'(bus.fifo_count), 32'(mq.size()));
        check("full",  32'(bus.tx_full),    32'(mq.size() == DEPTH));
        check("empty", 32'(bus.tx_empty),   32'(mq.size() == 0));
        check("ovf",   32'(bus.tx_ovf),     32'(m_ovf));
        if (bus.tx_busy && !prev_busy) rise_cyc.push_back(cyc);
        if (bus.tx_busy) begin
          busy_len++;
        end else if (prev_busy) begin
          len_log.push_back(busy_len);
          busy_len = 0;
        end
        prev_busy = bus.tx_busy;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [DL-1:0] d);
    bus.tx_req  = 1'b1;
    bus.tx_data = d;
    @(negedge clk);
    bus.tx_req  = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((bus.tx_busy || !bus.tx_empty) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n < budget), 32'd1);
    #1;
  endtask

  initial begin
    logic [9:0] a5_bits;
    int r0;
    int l0;
    int n;

    bus.tx_req  = 1'b0;
    bus.tx_data = '0;
    bus.cts     = 1'b0;

    // Reset state, while held and after release.
    tick(3);
    check("rst_tx",    32'(bus.tx),         32'd1);
    check("rst_busy",  32'(bus.tx_busy),    32'd0);
    check("rst_empty", 32'(bus.tx_empty),   32'd1);
    check("rst_full",  32'(bus.tx_full),    32'd0);
    check("rst_count", 32'(bus.fifo_count), 32'd0);
    check("rst_ovf",   32'(bus.tx_ovf),     32'd0);
    #2 rst_n = 1'b1;
    tick(2);
    check("rel_tx",    32'(bus.tx),         32'd1);
    check("rel_empty", 32'(bus.tx_empty),   32'd1);

    // Single word 0xA5: line falls one edge after the push edge.
    bus.cts = 1'b1;
    l0 = len_log.size();
    push(8'hA5);
    check("t1_pre_fall_tx", 32'(bus.tx),         32'd1);
    check("t1_count1",      32'(bus.fifo_count), 32'd1);
    tick(1);
    check("t1_fall_tx",     32'(bus.tx),         32'd0);
    check("t1_fall_busy",   32'(bus.tx_busy),    32'd1);
    a5_bits = 10'b11_0100_1010;
    tick(BC / 2);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("t1_bit%0d", k), 32'(bus.tx), 32'(a5_bits[k]));
      if (k < 9) tick(BC);
    end
    wait_idle(FRAME, "t1");
    if (len_log.size() > l0) check("t1_busy_len", 32'(len_log[l0]), 32'd160);
    else check("t1_busy_seen", 32'(len_log.size()), 32'(l0 + 1));

    // Three queued words with CTS low, then released back to back.
    bus.cts = 1'b0;
    r0 = rise_cyc.size();
    push(8'h00); check("t2_count1", 32'(bus.fifo_count), 32'd1);
    push(8'hFF); check("t2_count2", 32'(bus.fifo_count), 32'd2);
    push(8'h3C); check("t2_count3", 32'(bus.fifo_count), 32'd3);
    bus.cts = 1'b1;
    tick(1);
    check("t2_count_after_pop", 32'(bus.fifo_count), 32'd2);
    wait_idle(3 * (FRAME + 1) + 10, "t2");
    check("t2_frames", 32'(rise_cyc.size() - r0), 32'd3);
    if (rise_cyc.size() >= r0 + 3) begin
      check("t2_gap1", 32'(rise_cyc[r0+1] - rise_cyc[r0]),   32'd161);
      check("t2_gap2", 32'(rise_cyc[r0+2] - rise_cyc[r0+1]), 32'd161);
    end

    // Overflow: ten pushes into an eight-deep FIFO with CTS low.
    bus.cts = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      push(DL'(i));
      check($sformatf("t3_ovf%0d", i),   32'(bus.tx_ovf),     32'(i >= 9));
      check($sformatf("t3_count%0d", i), 32'(bus.fifo_count), 32'((i > 8) ? 8 : i));
      check($sformatf("t3_tx%0d", i),    32'(bus.tx),         32'd1);
    end
    check("t3_full", 32'(bus.tx_full), 32'd1);
    tick(1);
    check("t3_ovf_clear", 32'(bus.tx_ovf), 32'd0);
    bus.cts = 1'b1;
    wait_idle(8 * (FRAME + 1) + 10, "t3");
    check("t3_empty", 32'(bus.tx_empty), 32'd1);

    // CTS dropped mid-frame: frame finishes, next waits for CTS.
    push(8'h5A);
    push(8'hC3);
    tick(5 * BC);
    bus.cts = 1'b0;
    n = 0;
    while (bus.tx_busy && n < FRAME + 10) begin
      tick(1);
      n++;
    end
    check("t4_frame_end", 32'(n < FRAME + 10), 32'd1);
    tick(30);
    check("t4_hold_tx",    32'(bus.tx),         32'd1);
    check("t4_hold_busy",  32'(bus.tx_busy),    32'd0);
    check("t4_hold_count", 32'(bus.fifo_count), 32'd1);
    bus.cts = 1'b1;
    tick(1);
    check("t4_resume_busy", 32'(bus.tx_busy), 32'd1);
    check("t4_resume_tx",   32'(bus.tx),      32'd0);
    wait_idle(FRAME + 10, "t4");

    // Reset during data bit 3 with two words still queued.
    push(8'h96);
    push(8'h11);
    push(8'h22);
    tick(4 * BC + 3);
    check("t5_pre_count", 32'(bus.fifo_count), 32'd2);
    check("t5_pre_busy",  32'(bus.tx_busy),    32'd1);
    r0 = rise_cyc.size();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tx",    32'(bus.tx),         32'd1);
    check("t5_rst_count", 32'(bus.fifo_count), 32'd0);
    check("t5_rst_empty", 32'(bus.tx_empty),   32'd1);
    check("t5_rst_busy",  32'(bus.tx_busy),    32'd0);
    tick(3);
    #2 rst_n = 1'b1;
    tick(3 * FRAME);
    #1;
    check("t5_no_frame", 32'(rise_cyc.size() - r0), 32'd0);
    check("t5_idle_tx",  32'(bus.tx),               32'd1);

    // Random pushes and CTS toggling.
    for (int c = 0; c < 3000; c++) begin
      bus.tx_req  = ($urandom_range(0, 7) == 0);
      bus.tx_data = DL'($urandom);
      if ($urandom_range(0, 149) == 0) bus.cts = ~bus.cts;
      tick(1);
    end
    bus.tx_req = 1'b0;
    bus.cts    = 1'b1;
    wait_idle(DEPTH * (FRAME + 1) + FRAME + 10, "rand");

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
